// File: rtl/pipeline_defs_pkg.sv
// rtl/pipeline_defs_pkg.sv - shared state encodings for the pipeline sequencer and its decoder bench
package pipeline_defs_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FE    = 3'd1;
    localparam logic [2:0] ST_E1    = 3'd2;
    localparam logic [2:0] ST_E2    = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FE    = ST_FE,
        S_E1    = ST_E1,
        S_E2    = ST_E2,
        S_PAUSE = ST_PAUSE,
        S_HALT  = ST_HALT
    } state_t;

endpackage

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - fetch/execute phase sequencer with stepping, halt and retired-instruction count
module pipeline_sequencer
    import pipeline_defs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             restart,
    input  logic             stp,
    input  logic             extra1,
    input  logic             step_mode,
    input  logic             step,
    output logic             fe,
    output logic             e1,
    output logic             e2,
    output logic             halted,
    output logic             busy,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    state_t state_nxt;
    logic   retire;

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FE;
            S_FE:    state_nxt = S_E1;
            S_E1: begin
                // stop wins over a second-cycle request and retires nothing
                if (stp) begin
                    state_nxt = S_HALT;
                end else if (extra1) begin
                    state_nxt = S_E2;
                end else begin
                    retire    = 1'b1;
                    state_nxt = step_mode ? S_PAUSE : S_E1;
                end
            end
            S_E2: begin
                retire    = 1'b1;
                state_nxt = step_mode ? S_PAUSE : S_E1;
            end
            S_PAUSE: if (step || !step_mode) state_nxt = S_E1;
            S_HALT:  if (restart) state_nxt = S_FE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // wraps silently at 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign fe      = (state == S_FE);
    assign e1      = (state == S_E1);
    assign e2      = (state == S_E2);
    assign halted  = (state == S_HALT);
    assign busy    = (state == S_FE) || (state == S_E1) || (state == S_E2);
    assign state_o = state;

endmodule
